// File: rtl/fifo_pop_streamer_if.sv
// Valid/ready stream carrying words drained from a sync_fifo.
// The master drives valid and data; the slave returns ready.
interface fifo_pop_streamer_if #(
    parameter int DWIDTH = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo_pop_streamer.sv
// Drains a sync_fifo via pop/empty/out and re-presents its words as a valid/ready stream.
// Latency: first out_valid RD_LAT+1 cycles after the first pop, then one word per cycle.
// Backpressure: pops are credit-limited so that buffered plus in-flight words never exceed SKID_DEPTH.
module fifo_pop_streamer #(
    parameter int DWIDTH      = 16,
    parameter int RD_LAT      = 1,
    parameter int SKID_AWIDTH = 2,
    parameter int SKID_DEPTH  = 2**SKID_AWIDTH,
    parameter int CWIDTH      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [DWIDTH-1:0]   fifo_out,
    output logic                fifo_pop,
    input  logic                flush,
    fifo_pop_streamer_if.master strm,
    output logic [CWIDTH-1:0]   out_cnt,
    output logic                busy
);

    localparam int OW = SKID_AWIDTH + 1;
    localparam int SW = SKID_AWIDTH + 2;
    localparam int IW = $clog2(RD_LAT + 1);

    logic [RD_LAT-1:0]      vld_sr;
    logic [RD_LAT-1:0]      vld_sr_next;
    logic [OW-1:0]          occ;
    logic [OW-1:0]          occ_next;
    logic [SKID_AWIDTH-1:0] wptr;
    logic [SKID_AWIDTH-1:0] wptr_next;
    logic [SKID_AWIDTH-1:0] rptr;
    logic [SKID_AWIDTH-1:0] rptr_next;
    logic [CWIDTH-1:0]      cnt_next;
    logic [IW-1:0]          inflight;
    logic [SW-1:0]          credit_used;
    logic                   capture;
    logic                   fire;
    logic [DWIDTH-1:0]      skid [SKID_DEPTH];

    function automatic logic [SKID_AWIDTH-1:0] ptr_inc(input logic [SKID_AWIDTH-1:0] p);
        return (p == SKID_AWIDTH'(SKID_DEPTH - 1)) ? '0 : p + SKID_AWIDTH'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(vld_sr[i]);
        end
    end

    // Every word already popped holds a skid slot, whether it has landed yet or not.
    assign credit_used = SW'(occ) + SW'(inflight);
    assign fifo_pop    = !reset && !fifo_empty && !flush && (credit_used < SW'(SKID_DEPTH));

    assign capture       = vld_sr[RD_LAT-1];
    assign strm.out_valid = (occ != '0);
    assign fire          = strm.out_valid && strm.out_ready;
    assign strm.out_data  = strm.out_valid ? skid[rptr] : '0;
    assign busy          = (occ != '0) || (inflight != '0);

    always_comb begin
        vld_sr_next = RD_LAT'({vld_sr, fifo_pop});
        occ_next    = occ + OW'(capture) - OW'(fire);
        wptr_next   = capture ? ptr_inc(wptr) : wptr;
        rptr_next   = fire ? ptr_inc(rptr) : rptr;
        cnt_next    = fire ? out_cnt + CWIDTH'(1) : out_cnt;
        // A flush drops buffered and in-flight words but keeps the transfer count.
        if (flush) begin
            vld_sr_next = '0;
            occ_next    = '0;
            wptr_next   = '0;
            rptr_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_sr  <= '0;
            occ     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            out_cnt <= '0;
        end else begin
            vld_sr  <= vld_sr_next;
            occ     <= occ_next;
            wptr    <= wptr_next;
            rptr    <= rptr_next;
            out_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            skid[wptr] <= fifo_out;
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credit_used <= SW'(SKID_DEPTH));

    a_no_capture_when_full: assert property (@(posedge clk) disable iff (reset)
        !(capture && (occ == OW'(SKID_DEPTH))));

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Bench for fifo_pop_streamer: a sync_fifo model drives the DUT, a queue scoreboard checks every cycle,
// and four extra instances sweep RD_LAT=1..4.
`timescale 1ns/1ps
module tb_fifo_pop_streamer;
    localparam int DW    = 16;
    localparam int RDL   = 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [DW-1:0] fifo_out;
    logic          fifo_pop;
    logic          flush;
    logic [31:0]   out_cnt;
    logic          busy;
    logic          sw_rst;
    logic          sw_go;
    int            sw_done = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_pop_streamer_if #(.DWIDTH(DW)) dut_if ();

    fifo_pop_streamer #(
        .DWIDTH(DW), .RD_LAT(RDL), .SKID_AWIDTH(2), .SKID_DEPTH(DEPTH), .CWIDTH(32)
    ) u_dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
        .fifo_pop(fifo_pop), .flush(flush), .strm(dut_if), .out_cnt(out_cnt), .busy(busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    // sync_fifo contents and scoreboard of popped-but-undelivered words
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } sb_t;

    logic [DW-1:0] fifoq [$];
    sb_t           sb [$];
    logic [DW-1:0] got [$];
    int            cyc = 0;
    logic [31:0]   exp_cnt = 0;
    logic          m_valid;
    logic          m_pop;
    sb_t           m_ent;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_out_valid", dut_if.out_valid, 0);
            check("rst_out_data", dut_if.out_data, 0);
            check("rst_out_cnt", out_cnt, 0);
            check("rst_busy", busy, 0);
            check("rst_fifo_pop", fifo_pop, 0);
            sb.delete();
            exp_cnt = 0;
        end else begin
            if (sb.size() > 0) m_valid = (cyc - sb[0].t) >= (RDL + 1);
            else               m_valid = 1'b0;
            m_pop = !fifo_empty && !flush && (sb.size() < DEPTH);
            check("out_valid", dut_if.out_valid, m_valid);
            check("fifo_pop", fifo_pop, m_pop);
            check("busy", busy, sb.size() != 0);
            check("out_cnt", out_cnt, exp_cnt);
            if (m_valid) check("out_data", dut_if.out_data, sb[0].d);
            if (m_valid && dut_if.out_ready) begin
                got.push_back(dut_if.out_data);
                void'(sb.pop_front());
                exp_cnt++;
            end
            if (flush) begin
                sb.delete();
            end else if (m_pop) begin
                m_ent.d = fifoq[0];
                m_ent.t = cyc;
                sb.push_back(m_ent);
            end
        end
        cyc++;
    end

    int n_pop, stp, first_pop, first_val, dut_os, max_os;

    // One clock of the sync_fifo model; inputs change 1ns after the rising edge.
    task automatic step();
        logic p;
        @(negedge clk);
        p = fifo_pop;
        if (p) begin
            n_pop++;
            if (first_pop < 0) first_pop = stp;
        end
        if (dut_if.out_valid && first_val < 0) first_val = stp;
        dut_os = dut_os + (p ? 1 : 0) - ((dut_if.out_valid && dut_if.out_ready) ? 1 : 0);
        if (flush) dut_os = 0;
        if (dut_os > max_os) max_os = dut_os;
        stp++;
        @(posedge clk);
        #1;
        if (p && fifoq.size() > 0) fifo_out = fifoq.pop_front();
        else                       fifo_out = 16'hdead;
        fifo_empty = (fifoq.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifoq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input string nm, input logic tog);
        int k;
        k = 0;
        while ((sb.size() > 0 || fifoq.size() > 0) && k < 300) begin
            if (tog) dut_if.out_ready = ~dut_if.out_ready;
            step();
            k++;
        end
        check({nm, "_drained"}, (sb.size() == 0 && fifoq.size() == 0), 1);
    endtask

    task automatic check_seq(input string nm, input int n, input int base);
        check({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            check({nm, "_word"}, (i < got.size()) ? got[i] : 16'hffff, base + i);
        end
    endtask

    initial begin
        reset = 1'b1; sw_rst = 1'b1; sw_go = 1'b0;
        fifo_empty = 1'b1; fifo_out = 16'hdead; flush = 1'b0; dut_if.out_ready = 1'b0;
        stp = 0; n_pop = 0; first_pop = -1; first_val = -1; dut_os = 0; max_os = 0;
        #1;
        fifo_empty = 1'b0;
        #1;
        check("reset_out_valid", dut_if.out_valid, 0);
        check("reset_out_cnt", out_cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_fifo_pop", fifo_pop, 0);
        fifo_empty = 1'b1;
        step(); step();
        reset = 1'b0; sw_rst = 1'b0;
        step();

        // 1: free-running stream
        got.delete(); n_pop = 0; stp = 0; first_pop = -1; first_val = -1;
        for (int i = 0; i < 16; i++) push(16'(i));
        dut_if.out_ready = 1'b1;
        drain("t1", 1'b0);
        check_seq("t1", 16, 0);
        check("t1_out_cnt", out_cnt, 16);
        check("t1_busy_after", busy, 0);
        check("t1_pop_cycles", n_pop, 16);
        check("t1_first_latency", first_val - first_pop, RDL + 1);

        // 2: stall for 10 cycles
        got.delete(); n_pop = 0;
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(16'(i));
        for (int s = 0; s < 10; s++) begin
            step();
            if (s >= 3) check("t2_hold_data", dut_if.out_data, 0);
        end
        check("t2_stall_pops", n_pop, DEPTH);
        check("t2_stall_valid", dut_if.out_valid, 1);
        dut_if.out_ready = 1'b1;
        drain("t2", 1'b0);
        check_seq("t2", 16, 0);
        check("t2_out_cnt", out_cnt, 32);

        // 3: alternating ready with concurrent pushes
        got.delete(); max_os = 0; dut_os = 0;
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push(16'(200 + i));
            dut_if.out_ready = ~dut_if.out_ready;
            step();
        end
        drain("t3", 1'b1);
        check_seq("t3", 32, 200);
        check("t3_out_cnt", out_cnt, 64);
        check("t3_credit_bound", max_os <= DEPTH, 1);

        // 5: asynchronous reset with three words buffered
        got.delete();
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(50 + i));
        for (int s = 0; s < 4; s++) step();
        check("t5_pre_valid", dut_if.out_valid, 1);
        check("t5_pre_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", dut_if.out_valid, 0);
        check("t5_async_data", dut_if.out_data, 0);
        check("t5_async_cnt", out_cnt, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_pop", fifo_pop, 0);
        fifoq.delete(); fifo_empty = 1'b1; fifo_out = 16'hdead;
        step(); step();
        reset = 1'b0; dut_os = 0;
        step();
        for (int i = 0; i < 4; i++) push(16'(100 + i));
        dut_if.out_ready = 1'b1;
        drain("t5", 1'b0);
        check_seq("t5", 4, 100);
        check("t5_out_cnt", out_cnt, 4);

        // 4: flush with 5 accepted, 3 buffered, 1 in flight
        reset = 1'b1;
        step();
        reset = 1'b0; dut_os = 0;
        step();
        for (int i = 0; i < 16; i++) push(16'(i));
        dut_if.out_ready = 1'b1;
        for (int s = 0; s < 7; s++) step();
        dut_if.out_ready = 1'b0;
        step(); step();
        check("t4_pre_cnt", out_cnt, 5);
        check("t4_pre_valid", dut_if.out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_post_valid", dut_if.out_valid, 0);
        check("t4_post_busy", busy, 0);
        check("t4_post_cnt", out_cnt, 5);
        got.delete();
        dut_if.out_ready = 1'b1;
        drain("t4", 1'b0);
        check_seq("t4", 7, 9);
        check("t4_out_cnt", out_cnt, 12);

        // 6: latency sweep on the auxiliary instances
        sw_go = 1'b1;
        for (int i = 0; i < 200 && sw_done < 4; i++) @(posedge clk);
        check("sweep_done", sw_done, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1);
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int L  = g + 1;
        localparam int D  = L + 2;
        localparam int AW = (D > 4) ? 3 : 2;

        logic          sw_empty;
        logic          sw_pop;
        logic          sw_busy;
        logic [DW-1:0] sw_fout;
        logic [31:0]   sw_cnt;

        fifo_pop_streamer_if #(.DWIDTH(DW)) sw_if ();

        fifo_pop_streamer #(
            .DWIDTH(DW), .RD_LAT(L), .SKID_AWIDTH(AW), .SKID_DEPTH(D), .CWIDTH(32)
        ) u_sw (
            .clk(clk), .reset(sw_rst), .fifo_empty(sw_empty), .fifo_out(sw_fout),
            .fifo_pop(sw_pop), .flush(1'b0), .strm(sw_if), .out_cnt(sw_cnt), .busy(sw_busy)
        );

        initial begin
            logic [DW-1:0] pipe [4];
            logic          p;
            int            head, fp, fv, lv, nv;
            sw_empty = 1'b1; sw_fout = 16'hdead; sw_if.out_ready = 1'b1;
            head = 0; fp = -1; fv = -1; lv = -1; nv = 0;
            for (int k = 0; k < 4; k++) pipe[k] = 16'hdead;
            wait (sw_go);
            @(posedge clk);
            #1;
            sw_empty = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                p = sw_pop;
                if (p && fp < 0) fp = c;
                if (sw_if.out_valid) begin
                    if (fv < 0) fv = c;
                    lv = c;
                    check($sformatf("sweep%0d_data", L), sw_if.out_data, nv);
                    nv++;
                end
                @(posedge clk);
                #1;
                for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0] = p ? DW'(head) : 16'hdead;
                if (p) head++;
                sw_fout  = pipe[L-1];
                sw_empty = (head >= 12);
            end
            check($sformatf("sweep%0d_first_latency", L), fv - fp, L + 1);
            check($sformatf("sweep%0d_words", L), nv, 12);
            check($sformatf("sweep%0d_no_bubble", L), lv - fv, 11);
            check($sformatf("sweep%0d_out_cnt", L), sw_cnt, 12);
            check($sformatf("sweep%0d_busy", L), sw_busy, 0);
            sw_done++;
        end
    end

endmodule

// File: doc/fifo_pop_streamer.md
Name: fifo_pop_streamer

Overview:
- Read-side companion to sync_fifo: drains the FIFO through its push/pop/empty/out interface and presents the words on a valid/ready stream.
- Absorbs the FIFO's fixed BRAM read latency so the consumer never sees a bubble caused by it.
- Placed between a sequencer FIFO and any backpressuring consumer, such as a PE lane or a writeback path.
- Internal skid buffer and in-flight tracking guarantee that no popped word is ever lost under backpressure.

Parameters:
- DWIDTH, 16, data width; matches the attached sync_fifo.
- RD_LAT, 1, cycles from fifo_pop high to valid fifo_out; instantiate with `COMMON_BRAM_DELAY; legal range 1..4.
- SKID_AWIDTH, 2, skid-buffer address width.
- SKID_DEPTH, 2**SKID_AWIDTH, skid entries; must be >= RD_LAT+2.
- CWIDTH, 32, width of the out_cnt counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  empty flag from sync_fifo.
- fifo_out  in  DWIDTH  read data from sync_fifo; valid RD_LAT cycles after a pop.
- fifo_pop  out  1  pop request to sync_fifo.
- flush  in  1  synchronous discard of all buffered and in-flight words.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DWIDTH  stream data.
- out_cnt  out  CWIDTH  number of accepted stream transfers.
- busy  out  1  in-flight or buffered data present.

Behaviour:
- Reset (asynchronous, any cycle):
  - out_valid=0, out_data=0, out_cnt=0, busy=0, fifo_pop=0.
  - Skid pointers, occupancy and the in-flight shift register are cleared.
  - Words still in flight at reset are dropped.
- Pop issue:
  - fifo_pop = !fifo_empty && !flush && (occ + inflight) < SKID_DEPTH.
  - occ and inflight are registered values; fifo_pop depends only on those registers and the inputs named above.
  - inflight is the count of 1s in an RD_LAT-deep valid shift register. fifo_pop enters the register at stage 0 each cycle.
- Return capture:
  - When the last stage of the shift register is 1, fifo_out is written into the skid buffer at wptr, and wptr is incremented with wrap at SKID_DEPTH.
  - A return never finds the buffer full; this is guaranteed by the credit rule above.
- Output:
  - out_valid = (occ != 0).
  - out_data = skid[rptr], driven combinationally from the register-file head. It holds stable while out_valid && !out_ready.
  - On fire (out_valid && out_ready): rptr increments with wrap, and out_cnt increments with wrap at 2**CWIDTH.
- Occupancy update:
  - occ_next = occ + capture - fire.
  - A simultaneous capture and fire leaves occ unchanged.
  - occ width is SKID_AWIDTH+1.
- Ordering: output order equals pop order.
- Throughput:
  - With out_ready held at 1 and the FIFO non-empty, there is one word per cycle after an initial latency.
  - First out_valid appears RD_LAT+1 cycles after the first fifo_pop; the extra cycle is the skid write.
- Flush (sampled on posedge):
  - fifo_pop=0 in the flush cycle.
  - Next cycle: occ=0, rptr=wptr=0, shift register cleared, and returns arriving in the following RD_LAT cycles are discarded.
  - out_cnt is not cleared.
  - A fire in the flush cycle still counts.
- busy = (occ != 0) || (inflight != 0).
- fifo_empty rising while pops are in flight has no effect on returns already in flight.
- Backpressure: with out_ready=0 indefinitely, popping stops at occ+inflight = SKID_DEPTH. No overflow and no data loss.

Test Plan:
1. Stream with no backpressure: preload the FIFO with 0..15, out_ready=1.
   -> out_data 0..15 on consecutive cycles; out_cnt=16; busy=0 afterwards; fifo_pop high for exactly 16 cycles.
2. Stall: preload 0..15, out_ready=0 for 10 cycles, then 1.
   -> exactly SKID_DEPTH (4) pops during the stall; out_data holds 0 while stalled; the full sequence 0..15 is then delivered with no gaps or duplicates.
3. Alternating backpressure: out_ready toggles every cycle with 32 words pushed concurrently.
   -> all 32 words arrive in order; out_cnt=32; fifo_pop never causes occ+inflight to exceed 4.
4. Flush mid-stream: assert flush for 1 cycle after 5 words have been accepted, with 3 buffered and 1 in flight.
   -> out_valid=0 the next cycle; the in-flight word is discarded; streaming resumes at the next FIFO word (9); out_cnt keeps counting from 5.
5. Reset mid-operation: assert reset while occ=3.
   -> outputs 0 immediately, without waiting for a clock edge; after deassertion with the FIFO re-filled with 100..103, out_data is 100..103.
6. Latency sweep: RD_LAT=1..4 with SKID_DEPTH=RD_LAT+2 and out_ready=1.
   -> first out_valid RD_LAT+1 cycles after the first pop; sustained one word per cycle.
